// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_pkg
// Purpose : Shared types and helpers for the single-clock FIFO.
//           - read_mode_e : selects registered read or show-ahead output.
//           - ptr_width() : pointer width (address bits plus one wrap bit).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  typedef enum logic {
    REG_READ   = 1'b0,
    SHOW_AHEAD = 1'b1
  } read_mode_e;

  // The extra MSB is the wrap bit that distinguishes full from empty when
  // the address bits of the two pointers are equal.
  function automatic int ptr_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_ram
// Purpose : DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read.
//           Contents are not reset.
// Ports   : clk   - write clock
//           we    - write enable
//           waddr - write address
//           wdata - write data
//           raddr - read address
//           rdata - read data (combinational from raddr)
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_SIZE-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int c_depth = 2 ** ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem_q [c_depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with occupancy count, full/empty and
//           programmable almost-full/almost-empty flags, selectable read mode
//           (registered or show-ahead), synchronous flush and sticky
//           overflow/underflow error flags.
// Ports   : clk          - clock, rising edge
//           rst          - asynchronous active-high reset
//           flush        - synchronous clear of contents
//           w_en / data  - push request / push data
//           r_en         - pop request
//           out          - read data
//           r_valid      - out holds valid popped (or head) data
//           full / empty - count == DEPTH / count == 0
//           almost_full  - count >= AF_THRESH
//           almost_empty - count <= AE_THRESH
//           count        - occupancy 0..DEPTH
//           overflow     - sticky: push attempted while full
//           underflow    - sticky: pop attempted while empty
//           clr_err      - synchronous clear of the sticky error flags
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 3,
  parameter int SHOW_AHEAD = 0,
  parameter int AF_THRESH  = (2 ** ADDR_SIZE) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_SIZE:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  import sync_fifo_pkg::*;

  localparam int                 c_depth  = 2 ** ADDR_SIZE;
  localparam int                 c_ptr_w  = ptr_width(ADDR_SIZE);
  localparam logic [c_ptr_w-1:0] c_af     = c_ptr_w'(AF_THRESH);
  localparam logic [c_ptr_w-1:0] c_ae     = c_ptr_w'(AE_THRESH);
  localparam logic [c_ptr_w-1:0] c_one    = c_ptr_w'(1);
  localparam logic               c_af_rst = (AF_THRESH == 0);
  localparam read_mode_e         c_mode   = (SHOW_AHEAD != 0) ? sync_fifo_pkg::SHOW_AHEAD
                                                              : sync_fifo_pkg::REG_READ;

  if ((AF_THRESH > c_depth) || (AE_THRESH >= c_depth)) begin : g_bad_params
    $fatal(1, "sync_fifo: require AF_THRESH <= DEPTH and AE_THRESH < DEPTH");
  end

  logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0]    count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  push, pop, ovf_evt, udf_evt;
  logic [ADDR_SIZE-1:0]  wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  assign wr_addr = wr_ptr_q[ADDR_SIZE-1:0];
  assign rd_addr = rd_ptr_q[ADDR_SIZE-1:0];

  always_comb begin
    // Blocking uses the registered flags only: no pass-through when full or
    // empty even if the opposite side is active. A flush cycle discards both
    // requests and raises no error events.
    push    = w_en & ~full_q  & ~flush;
    pop     = r_en & ~empty_q & ~flush;
    ovf_evt = w_en &  full_q  & ~flush;
    udf_evt = r_en &  empty_q & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + c_one;
      if (pop)  rd_ptr_d = rd_ptr_q + c_one;
      case ({push, pop})
        2'b10:   count_d = count_q + c_one;
        2'b01:   count_d = count_q - c_one;
        default: count_d = count_q;
      endcase
    end

    // Flags are computed from next state so they are exact right after the edge.
    full_d  = (wr_ptr_d[c_ptr_w-1] != rd_ptr_d[c_ptr_w-1]) &&
              (wr_ptr_d[ADDR_SIZE-1:0] == rd_ptr_d[ADDR_SIZE-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
    af_d    = (count_d >= c_af);
    ae_d    = (count_d <= c_ae);

    // A new event beats a coincident clear.
    ovf_d = ovf_evt | (ovf_q & ~clr_err);
    udf_d = udf_evt | (udf_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= c_af_rst;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_addr),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  if (c_mode == sync_fifo_pkg::REG_READ) begin : g_reg_read
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  r_valid_q, r_valid_d;

    always_comb begin
      out_d     = out_q;
      r_valid_d = pop;
      if (pop) out_d = rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q     <= '0;
        r_valid_q <= 1'b0;
      end else begin
        out_q     <= out_d;
        r_valid_q <= r_valid_d;
      end
    end

    assign out     = out_q;
    assign r_valid = r_valid_q;
  end else begin : g_show_ahead
    // Head entry falls through; don't-care while empty.
    assign out     = rd_data;
    assign r_valid = ~empty_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_fifo
// Purpose : Self-checking bench for sync_fifo: a queue-based reference model
//           compared every cycle against the registered-read instance, plus
//           directed literal expectations on both read modes.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // registered-read instance
  logic          flush = 0, w_en = 0, r_en = 0, clr_err = 0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] out;
  logic          r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  // show-ahead instance
  logic          sa_flush = 0, sa_w_en = 0, sa_r_en = 0, sa_clr_err = 0;
  logic [DW-1:0] sa_data = '0;
  logic [DW-1:0] sa_out;
  logic          sa_r_valid, sa_full, sa_empty, sa_af, sa_ae, sa_ovf, sa_udf;
  logic [AW:0]   sa_count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .SHOW_AHEAD(0),
              .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data(data), .r_en(r_en),
    .out(out), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .SHOW_AHEAD(1),
              .AF_THRESH(AF), .AE_THRESH(AE)) dut_sa (
    .clk(clk), .rst(rst), .flush(sa_flush), .w_en(sa_w_en), .data(sa_data), .r_en(sa_r_en),
    .out(sa_out), .r_valid(sa_r_valid), .full(sa_full), .empty(sa_empty),
    .almost_full(sa_af), .almost_empty(sa_ae), .count(sa_count),
    .overflow(sa_ovf), .underflow(sa_udf), .clr_err(sa_clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model (queue semantics) ----------------
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_out = '0;
  logic          m_rv  = 1'b0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic model_step();
    bit do_push, do_pop;
    int sz;
    sz = m_q.size();
    if (rst) begin
      m_q.delete(); m_out = '0; m_rv = 0; m_ovf = 0; m_udf = 0;
    end else if (flush) begin
      m_q.delete(); m_rv = 0;
      m_ovf = m_ovf & ~clr_err;
      m_udf = m_udf & ~clr_err;
    end else begin
      do_push = w_en && (sz < DEPTH);
      do_pop  = r_en && (sz > 0);
      m_ovf = (w_en && sz == DEPTH) || (m_ovf && !clr_err);
      m_udf = (r_en && sz == 0)     || (m_udf && !clr_err);
      if (do_pop) begin m_out = m_q.pop_front(); m_rv = 1; end
      else m_rv = 0;
      if (do_push) m_q.push_back(data);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("cmp_count",   32'(count),        32'(m_q.size()));
      check("cmp_empty",   32'(empty),        32'(m_q.size() == 0));
      check("cmp_full",    32'(full),         32'(m_q.size() == DEPTH));
      check("cmp_afull",   32'(almost_full),  32'(m_q.size() >= AF));
      check("cmp_aempty",  32'(almost_empty), 32'(m_q.size() <= AE));
      check("cmp_rvalid",  32'(r_valid),      32'(m_rv));
      check("cmp_out",     32'(out),          32'(m_out));
      check("cmp_ovf",     32'(overflow),     32'(m_ovf));
      check("cmp_udf",     32'(underflow),    32'(m_udf));
    end
  end

  // drive one cycle on the registered-read instance, return at next negedge
  task automatic step(input logic we, input logic [DW-1:0] d, input logic re,
                      input logic fl, input logic ce);
    w_en = we; data = d; r_en = re; flush = fl; clr_err = ce;
    @(negedge clk);
    w_en = 0; r_en = 0; flush = 0; clr_err = 0;
  endtask

  task automatic sa_step(input logic we, input logic [DW-1:0] d, input logic re);
    sa_w_en = we; sa_data = d; sa_r_en = re;
    @(negedge clk);
    sa_w_en = 0; sa_r_en = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_count",  32'(count),        32'd0);
    check("rst_empty",  32'(empty),        32'd1);
    check("rst_full",   32'(full),         32'd0);
    check("rst_afull",  32'(almost_full),  32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_rvalid", 32'(r_valid),      32'd0);
    check("rst_out",    32'(out),          32'd0);
    check("rst_ovf",    32'(overflow),     32'd0);
    rst = 0;
    @(negedge clk);

    // reset mid-stream, asserted between edges
    for (int i = 0; i < 5; i++) step(1, DW'(8'h01 + i), 0, 0, 0);
    check("pre_rst_count", 32'(count), 32'd5);
    step(0, '0, 1, 0, 0);
    check("pre_rst_out",    32'(out),     32'h01);
    check("pre_rst_rvalid", 32'(r_valid), 32'd1);
    #2 rst = 1;
    #1;
    check("async_rst_count",  32'(count),   32'd0);
    check("async_rst_empty",  32'(empty),   32'd1);
    check("async_rst_rvalid", 32'(r_valid), 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // fill and overflow
    for (int i = 0; i < 8; i++) begin
      step(1, DW'(8'h10 + i), 0, 0, 0);
      if (i == 4) check("fill_af_at5", 32'(almost_full), 32'd0);
      if (i == 5) check("fill_af_at6", 32'(almost_full), 32'd1);
      if (i == 6) check("fill_nfull7", 32'(full),        32'd0);
    end
    check("fill_full", 32'(full), 32'd1);
    step(1, 8'hFF, 0, 0, 0);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_count", 32'(count),    32'd8);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 1, 0, 0);
      check("drain_out",    32'(out),     32'(8'h10 + i));
      check("drain_rvalid", 32'(r_valid), 32'd1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // underflow and clear
    step(0, '0, 1, 0, 0);
    check("udf_set",    32'(underflow), 32'd1);
    check("udf_count",  32'(count),     32'd0);
    check("udf_rvalid", 32'(r_valid),   32'd0);
    step(0, '0, 0, 0, 1);
    check("udf_clr", 32'(underflow), 32'd0);
    check("ovf_clr", 32'(overflow),  32'd0);
    step(0, '0, 1, 0, 1);
    check("udf_evt_wins", 32'(underflow), 32'd1);
    step(0, '0, 0, 0, 1);

    // simultaneous push/pop at count 4, pointers wrap
    for (int i = 0; i < 4; i++) step(1, DW'(8'h20 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, DW'(8'h24 + i), 1, 0, 0);
      check("pp_out",    32'(out),     32'(8'h20 + i));
      check("pp_count",  32'(count),   32'd4);
      check("pp_rvalid", 32'(r_valid), 32'd1);
    end
    step(0, '0, 0, 0, 0);
    check("pp_rvalid_drop", 32'(r_valid), 32'd0);

    // flush with concurrent push at count 3, overflow held
    for (int i = 0; i < 4; i++) step(1, DW'(8'h40 + i), 0, 0, 0);
    step(1, 8'hFF, 0, 0, 0);
    check("fl_pre_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0);
    check("fl_pre_count", 32'(count), 32'd3);
    step(1, 8'hEE, 0, 1, 0);
    check("fl_count",  32'(count),        32'd0);
    check("fl_empty",  32'(empty),        32'd1);
    check("fl_aempty", 32'(almost_empty), 32'd1);
    check("fl_ovf",    32'(overflow),     32'd1);
    check("fl_udf",    32'(underflow),    32'd0);
    check("fl_rvalid", 32'(r_valid),      32'd0);
    step(1, 8'h55, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    check("fl_next_out", 32'(out),   32'h55);
    check("fl_after",    32'(empty), 32'd1);

    // show-ahead instance
    check("sa_init_empty",  32'(sa_empty),   32'd1);
    check("sa_init_rvalid", 32'(sa_r_valid), 32'd0);
    sa_step(1, 8'hA5, 0);
    check("sa_rvalid",  32'(sa_r_valid), 32'd1);
    check("sa_out",     32'(sa_out),     32'hA5);
    check("sa_count",   32'(sa_count),   32'd1);
    sa_step(0, '0, 0);
    check("sa_hold_out",    32'(sa_out),     32'hA5);
    check("sa_hold_rvalid", 32'(sa_r_valid), 32'd1);
    sa_step(0, '0, 1);
    check("sa_pop_empty",  32'(sa_empty),   32'd1);
    check("sa_pop_rvalid", 32'(sa_r_valid), 32'd0);
    check("sa_pop_udf",    32'(sa_udf),     32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
